// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

    // FORCE is a one-cycle state in which the RAS wins over the CPU.
    typedef enum logic {NORMAL, FORCE} arb_state_t;

    // Requester that owns the read data returned in the next cycle.
    typedef enum logic [1:0] {NONE, CPU, RAS} rd_owner_t;

    // A RAS access is always a full-word write.
    localparam logic [2:0] RAS_STRCTRL_WR = 3'b100;
    localparam logic [3:0] RAS_WEN_FULL   = 4'hF;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive cycles the RAS has lost to the CPU.
// Latency: the count updates one cycle after inc_i; at_limit_o decodes the current count.
// Backpressure: none; any cycle without inc_i clears the count.
//
// Ports:
//   clk, Rst   - clock and asynchronous active-high reset
//   inc_i      - this cycle is contended (RAS requesting, CPU holding the port)
//   cnt_o      - current wait count
//   at_limit_o - count equals STARVE_LIMIT-1: one more contended cycle forces a grant
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter  int unsigned STARVE_LIMIT = 8,
    localparam int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_limit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (inc_i) begin
            // Hold at STARVE_LIMIT rather than wrapping back to zero.
            if (cnt_q == CNT_W'(STARVE_LIMIT)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign at_limit_o = (cnt_q == CNT_W'(STARVE_LIMIT - 1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-side memory port between the CPU load/store path and the RAS spill/fill engine.
// Latency: grant and port muxing are combinational; read data returns one cycle after the grant.
// Backpressure: the CPU wins contention. After STARVE_LIMIT lost cycles the CPU is held for one cycle via cpu_hold.
//
// Ports:
//   clk, Rst                 - clock and asynchronous active-high reset
//   cpu_*                    - CPU request (qualified by cpu_sel), cpu_dout load data, cpu_hold stall
//   ras_req/wr/addr/din      - RAS request and payload, held stable until ras_gnt
//   ras_gnt                  - RAS owns the port this cycle
//   ras_rvalid/ras_dout      - RAS read return, one cycle after a read grant
//   mem_*                    - memory port (mem_dout has one-cycle read latency)
//   perf_clr, perf_*         - grant/force counters, present only with DMEM_ARB_PERF_EN defined
//
// Optional feature macro: DMEM_ARB_PERF_EN
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter  int unsigned STARVE_LIMIT = 8,
    localparam int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic        clk,
    input  logic        Rst,
`ifdef DMEM_ARB_PERF_EN
    input  logic        perf_clr,
    output logic [31:0] perf_cpu,
    output logic [31:0] perf_ras,
    output logic [31:0] perf_force,
`endif
    input  logic        cpu_sel,
    input  logic        cpu_rea,
    input  logic        cpu_wea,
    input  logic [3:0]  cpu_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    input  logic [2:0]  cpu_storecntrl,
    output logic [31:0] cpu_dout,
    output logic        cpu_hold,
    input  logic        ras_req,
    input  logic        ras_wr,
    input  logic [31:0] ras_addr,
    input  logic [31:0] ras_din,
    output logic        ras_gnt,
    output logic        ras_rvalid,
    output logic [31:0] ras_dout,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [2:0]  mem_strctrl,
    input  logic [31:0] mem_dout
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    rd_owner_t        rd_owner_q;
    rd_owner_t        rd_owner_d;

    logic             cpu_act;
    logic             cpu_own;
    logic             ras_own;
    logic             contended;
    logic             at_limit;
    logic [CNT_W-1:0] wait_cnt;

    assign cpu_act   = cpu_sel & (cpu_rea | cpu_wea);
    assign contended = (state_q == NORMAL) & cpu_act & ras_req;
    assign cpu_own   = (state_q == NORMAL) & cpu_act;
    // FORCE is only entered with ras_req high, and the RAS holds it until granted.
    assign ras_own   = (state_q == FORCE) | (~cpu_act & ras_req);

    dmem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .Rst        (Rst),
        .inc_i      (contended),
        .cnt_o      (wait_cnt),
        .at_limit_o (at_limit)
    );

    // Port mux. When the port is idle the CPU payload is left on the bus with mem_en low.
    always_comb begin
        mem_en      = 1'b0;
        mem_wen     = 4'h0;
        mem_addr    = cpu_addr;
        mem_din     = cpu_din;
        mem_strctrl = cpu_storecntrl;
        if (ras_own) begin
            mem_en      = 1'b1;
            mem_wen     = ras_wr ? RAS_WEN_FULL : 4'h0;
            mem_addr    = ras_addr;
            mem_din     = ras_din;
            mem_strctrl = ras_wr ? RAS_STRCTRL_WR : 3'b000;
        end else if (cpu_own) begin
            mem_en      = 1'b1;
            mem_wen     = cpu_en;
        end
    end

    always_comb begin
        state_d = NORMAL;
        if (contended && at_limit) begin
            state_d = FORCE;
        end
        rd_owner_d = NONE;
        if (ras_own && !ras_wr) begin
            rd_owner_d = RAS;
        end else if (cpu_own && cpu_rea) begin
            rd_owner_d = CPU;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= NORMAL;
            rd_owner_q <= NONE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign ras_gnt    = ras_own;
    assign cpu_hold   = (state_q == FORCE);
    assign ras_rvalid = (rd_owner_q == RAS);
    assign ras_dout   = mem_dout;
    assign cpu_dout   = mem_dout;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] cpu_grant_cnt_q;
    logic [31:0] ras_grant_cnt_q;
    logic [31:0] force_cnt_q;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            cpu_grant_cnt_q <= '0;
            ras_grant_cnt_q <= '0;
            force_cnt_q     <= '0;
        end else if (perf_clr) begin
            cpu_grant_cnt_q <= '0;
            ras_grant_cnt_q <= '0;
            force_cnt_q     <= '0;
        end else begin
            if (cpu_own) begin
                cpu_grant_cnt_q <= cpu_grant_cnt_q + 32'd1;
            end
            if (ras_own) begin
                ras_grant_cnt_q <= ras_grant_cnt_q + 32'd1;
            end
            if (state_q == FORCE) begin
                force_cnt_q <= force_cnt_q + 32'd1;
            end
        end
    end

    assign perf_cpu   = cpu_grant_cnt_q;
    assign perf_ras   = ras_grant_cnt_q;
    assign perf_force = force_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a one-cycle-latency memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        Rst;
    logic        cpu_sel;
    logic        cpu_rea;
    logic        cpu_wea;
    logic [3:0]  cpu_en;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_din;
    logic [2:0]  cpu_storecntrl;
    logic [31:0] cpu_dout;
    logic        cpu_hold;
    logic        ras_req;
    logic        ras_wr;
    logic [31:0] ras_addr;
    logic [31:0] ras_din;
    logic        ras_gnt;
    logic        ras_rvalid;
    logic [31:0] ras_dout;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [2:0]  mem_strctrl;
    logic [31:0] mem_dout;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] mem_rdata;

    dmem_port_arbiter dut (
        .clk            (clk),
        .Rst            (Rst),
        .cpu_sel        (cpu_sel),
        .cpu_rea        (cpu_rea),
        .cpu_wea        (cpu_wea),
        .cpu_en         (cpu_en),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_storecntrl (cpu_storecntrl),
        .cpu_dout       (cpu_dout),
        .cpu_hold       (cpu_hold),
        .ras_req        (ras_req),
        .ras_wr         (ras_wr),
        .ras_addr       (ras_addr),
        .ras_din        (ras_din),
        .ras_gnt        (ras_gnt),
        .ras_rvalid     (ras_rvalid),
        .ras_dout       (ras_dout),
        .mem_en         (mem_en),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_strctrl    (mem_strctrl),
        .mem_dout       (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory, one-cycle read latency, byte write enables.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen != 4'h0) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wen[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_din[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[11:2]];
            end
        end
    end
    assign mem_dout = mem_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_sel = 1'b0; cpu_rea = 1'b0; cpu_wea = 1'b0; cpu_en = 4'h0;
        cpu_addr = 32'h0; cpu_din = 32'h0; cpu_storecntrl = 3'b000;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem_rdata = 32'h0;
        cpu_idle();
        ras_req = 1'b0; ras_wr = 1'b0; ras_addr = 32'h0; ras_din = 32'h0;
        Rst = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_ras_gnt", 32'(ras_gnt), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_ras_rvalid", 32'(ras_rvalid), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(NORMAL));
        check("rst_wait_cnt", 32'(dut.u_starve.cnt_q), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        Rst = 1'b0;
        tick();

        // CPU load of 0x2010, RAS idle
        cpu_sel = 1'b1; cpu_rea = 1'b1; cpu_addr = 32'h0000_2010;
        #1;
        check("ld_mem_en", 32'(mem_en), 32'd1);
        check("ld_mem_addr", mem_addr, 32'h0000_2010);
        check("ld_mem_wen", 32'(mem_wen), 32'd0);
        check("ld_ras_gnt", 32'(ras_gnt), 32'd0);
        tick();
        cpu_idle();
        #1;
        check("ld_cpu_dout", cpu_dout, 32'hA500_0004);
        check("ld_no_rvalid", 32'(ras_rvalid), 32'd0);
        tick();

        // RAS read of 0x2100, CPU idle
        ras_req = 1'b1; ras_wr = 1'b0; ras_addr = 32'h0000_2100;
        #1;
        check("rrd_gnt", 32'(ras_gnt), 32'd1);
        check("rrd_mem_addr", mem_addr, 32'h0000_2100);
        check("rrd_mem_wen", 32'(mem_wen), 32'd0);
        tick();
        ras_req = 1'b0;
        #1;
        check("rrd_rvalid", 32'(ras_rvalid), 32'd1);
        check("rrd_dout", ras_dout, 32'hA500_0040);
        tick();
        check("rrd_rvalid_off", 32'(ras_rvalid), 32'd0);

        // RAS write blocked by 3 CPU store cycles
        ras_req = 1'b1; ras_wr = 1'b1; ras_addr = 32'h0000_2200; ras_din = 32'hDEAD_BEEF;
        cpu_sel = 1'b1; cpu_wea = 1'b1; cpu_en = 4'hF; cpu_addr = 32'h0000_2300;
        cpu_din = 32'h1122_3344; cpu_storecntrl = 3'b100;
        #1;
        check("st_mem_addr", mem_addr, 32'h0000_2300);
        check("st_mem_din", mem_din, 32'h1122_3344);
        for (int i = 0; i < 3; i++) begin
            check("st_ras_gnt_blocked", 32'(ras_gnt), 32'd0);
            tick();
        end
        cpu_idle();
        #1;
        check("wr_wait_cnt", 32'(dut.u_starve.cnt_q), 32'd3);
        check("wr_gnt", 32'(ras_gnt), 32'd1);
        check("wr_mem_wen", 32'(mem_wen), 32'hF);
        check("wr_mem_strctrl", 32'(mem_strctrl), 32'd4);
        check("wr_mem_din", mem_din, 32'hDEAD_BEEF);
        check("wr_mem_addr", mem_addr, 32'h0000_2200);
        tick();
        ras_req = 1'b0; ras_wr = 1'b0;
        #1;
        check("wr_wait_clr", 32'(dut.u_starve.cnt_q), 32'd0);
        check("wr_no_rvalid", 32'(ras_rvalid), 32'd0);
        ras_req = 1'b1;
        #1;
        check("wrbk_gnt", 32'(ras_gnt), 32'd1);
        tick();
        ras_req = 1'b0;
        #1;
        check("wrbk_rvalid", 32'(ras_rvalid), 32'd1);
        check("wrbk_dout", ras_dout, 32'hDEAD_BEEF);
        tick();

        // Starvation: 8 contended cycles, then one FORCE cycle
        cpu_sel = 1'b1; cpu_rea = 1'b1; cpu_addr = 32'h0000_2010;
        ras_req = 1'b1; ras_wr = 1'b0; ras_addr = 32'h0000_2100;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("sv_gnt", 32'(ras_gnt), 32'd0);
            check("sv_hold", 32'(cpu_hold), 32'd0);
            check("sv_wait_cnt", 32'(dut.u_starve.cnt_q), 32'(i));
            tick();
        end
        check("fc_state", 32'(dut.state_q), 32'(FORCE));
        check("fc_hold", 32'(cpu_hold), 32'd1);
        check("fc_gnt", 32'(ras_gnt), 32'd1);
        check("fc_mem_addr", mem_addr, 32'h0000_2100);
        tick();
        ras_req = 1'b0;
        #1;
        check("af_hold", 32'(cpu_hold), 32'd0);
        check("af_gnt", 32'(ras_gnt), 32'd0);
        check("af_mem_addr", mem_addr, 32'h0000_2010);
        check("af_mem_en", 32'(mem_en), 32'd1);
        check("af_wait_cnt", 32'(dut.u_starve.cnt_q), 32'd0);
        check("af_rvalid", 32'(ras_rvalid), 32'd1);
        check("af_ras_dout", ras_dout, 32'hA500_0040);
        tick();
        cpu_idle();
        #1;
        check("af_cpu_dout", cpu_dout, 32'hA500_0004);
        check("af_rvalid_off", 32'(ras_rvalid), 32'd0);
        tick();

        // Reset in the cycle after a RAS read grant drops the read
        ras_req = 1'b1; ras_wr = 1'b0; ras_addr = 32'h0000_2100;
        #1;
        check("rs_gnt", 32'(ras_gnt), 32'd1);
        tick();
        ras_req = 1'b0;
        #1;
        check("rs_rvalid_pre", 32'(ras_rvalid), 32'd1);
        Rst = 1'b1;
        #1;
        check("rs_rvalid", 32'(ras_rvalid), 32'd0);
        check("rs_state", 32'(dut.state_q), 32'(NORMAL));
        check("rs_wait_cnt", 32'(dut.u_starve.cnt_q), 32'd0);
        tick();
        Rst = 1'b0;
        tick();
        ras_req = 1'b1; ras_addr = 32'h0000_2200;
        #1;
        check("rs2_gnt", 32'(ras_gnt), 32'd1);
        tick();
        ras_req = 1'b0;
        #1;
        check("rs2_rvalid", 32'(ras_rvalid), 32'd1);
        check("rs2_dout", ras_dout, 32'hDEAD_BEEF);
        tick();

        // MMIO CPU access (cpu_sel=0) does not block the RAS
        cpu_sel = 1'b0; cpu_rea = 1'b1; cpu_addr = 32'h0000_0040;
        ras_req = 1'b1; ras_wr = 1'b0; ras_addr = 32'h0000_2300;
        #1;
        check("mm_gnt", 32'(ras_gnt), 32'd1);
        check("mm_mem_addr", mem_addr, 32'h0000_2300);
        check("mm_hold", 32'(cpu_hold), 32'd0);
        tick();
        ras_req = 1'b0; cpu_idle();
        #1;
        check("mm_wait_cnt", 32'(dut.u_starve.cnt_q), 32'd0);
        check("mm_rvalid", 32'(ras_rvalid), 32'd1);
        check("mm_dout", ras_dout, 32'h1122_3344);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-side port of the shared instruction/data memory between the CPU load/store path and the RAS spill/fill engine.
- Replaces the implicit "RAS may use the port whenever the CPU is idle" rule with an explicit req/gnt handshake and registered read-return routing.
- Adds a starvation guard that briefly stalls the CPU through mem_hold so RAS traffic always makes progress.
- Sits between the memory controller's region decode and the memory interface instance.

Parameters:
- STARVE_LIMIT, 8, number of consecutive contended cycles RAS may lose before a forced grant. Legal range is 2..255.
- CNT_W, $clog2(STARVE_LIMIT+1), width of the wait counter. This is derived and must not be overridden.

Ports:
- clk  in  1  system clock
- Rst  in  1  asynchronous, active-high reset
- cpu_sel  in  1  CPU address decodes to memory (not MMIO); qualifies cpu_rea/cpu_wea
- cpu_rea  in  1  CPU load request
- cpu_wea  in  1  CPU store request
- cpu_en  in  4  CPU byte write enables
- cpu_addr  in  32  CPU byte address
- cpu_din  in  32  CPU store data
- cpu_storecntrl  in  3  CPU store-width control
- cpu_dout  out  32  load data to CPU
- cpu_hold  out  1  stall to CPU (drives rbus.mem_hold)
- ras_req  in  1  RAS access request
- ras_wr  in  1  1 = write, 0 = read; valid with ras_req
- ras_addr  in  32  RAS byte address
- ras_din  in  32  RAS write data (always full word)
- ras_gnt  out  1  RAS access accepted this cycle
- ras_rvalid  out  1  ras_dout valid
- ras_dout  out  32  RAS read data
- mem_en  out  1  memory port enable
- mem_wen  out  4  memory byte write enables
- mem_addr  out  32  memory address (unmodified; the base offset is applied downstream)
- mem_din  out  32  memory write data
- mem_strctrl  out  3  memory store control
- mem_dout  in  32  memory read data, one-cycle latency

Behaviour:
- Definitions:
  - cpu_act = cpu_sel & (cpu_rea | cpu_wea).
  - Reset values: state=NORMAL, wait_cnt=0, rd_owner=NONE, ras_rvalid=0. All other outputs are combinational from this state, so at reset ras_gnt=0 and cpu_hold=0.
- State NORMAL:
  - cpu_act=1: the CPU owns the port. mem_* come from cpu_*, and mem_en=1.
  - cpu_act=1 and ras_req=1: ras_gnt=0 and wait_cnt increments.
  - cpu_act=0 and ras_req=1: ras_gnt=1 and the RAS owns the port. mem_wen = ras_wr ? 4'b1111 : 0, mem_strctrl = ras_wr ? 3'b100 : 3'b000, and wait_cnt clears.
  - Neither requester active: mem_en=0, mem_wen=0, and wait_cnt clears.
  - When wait_cnt==STARVE_LIMIT-1 and the cycle is contended, the next state is FORCE.
- State FORCE (lasts exactly 1 cycle):
  - cpu_hold=1, ras_gnt=1, and the RAS owns the port. The CPU request is ignored; the CPU holds its request stable while cpu_hold=1.
  - Next state is NORMAL and wait_cnt clears.
- cpu_hold is 0 in every state other than FORCE.
- The RAS keeps ras_req and its payload stable until it sees ras_gnt. Deasserting ras_req before grant is legal only when wait_cnt has also gone idle. FORCE is entered only while ras_req=1.
- Read return:
  - rd_owner is registered each cycle: RAS if ras_gnt & ~ras_wr, CPU if the CPU owned a load, otherwise NONE.
  - ras_rvalid = (rd_owner==RAS). ras_dout = mem_dout. cpu_dout = mem_dout.
  - Read latency to the requester is 1 cycle after grant.
- Back-to-back RAS grants are allowed. Each read produces its own ras_rvalid pulse in the following cycle.
- Rst asserted mid-operation returns the block to the reset values immediately (asynchronously). Any in-flight RAS read is dropped with no rvalid.
- wait_cnt saturates and never wraps.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined, the block adds three 32-bit wrapping counters: cpu_grant_cnt, ras_grant_cnt and force_cnt. They are exposed on the outputs perf_cpu, perf_ras and perf_force, and are cleared by Rst or by the input perf_clr.
- When undefined, these ports and counters do not exist.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum logic {NORMAL, FORCE} arb_state_t;
  - typedef enum logic [1:0] {NONE, CPU, RAS} rd_owner_t;
  - the constants RAS_STRCTRL_WR=3'b100 and RAS_WEN_FULL=4'hF.
- One sub-module is natural: dmem_arb_starve_ctr, the saturating wait counter with a limit-compare output.

Test Plan:
- CPU load to 0x2010 with ras_req=0: mem_en=1, mem_addr=0x2010, and cpu_dout equals the memory word the next cycle. ras_gnt stays 0.
- RAS read of 0x2100 with the CPU idle: ras_gnt=1 in the same cycle, then ras_rvalid=1 one cycle later with ras_dout equal to the stored word.
- RAS write 0xDEADBEEF to 0x2200 while the CPU stores for 3 cycles (STARVE_LIMIT=8): ras_gnt=0 for 3 cycles, then granted on cycle 4 with mem_wen=4'hF and mem_strctrl=3'b100.
- Continuous CPU traffic with ras_req held high: FORCE is reached after exactly 8 contended cycles. cpu_hold=1 and ras_gnt=1 for one cycle only, and the CPU request completes on the following cycle with its data unchanged.
- Assert Rst in the cycle after a RAS read grant: ras_rvalid=0, state=NORMAL and wait_cnt=0. The next grant behaves normally.
- With cpu_sel=0 (MMIO access) and ras_req=1: the RAS is granted immediately and wait_cnt does not increment.
